tx_link_ctrl: RTL
=================

Name: tx_link_ctrl

Overview:
Parametrised single-lane JESD204B transmit link controller. It generates the octet stream that feeds the 8b/10b encoder: code group synchronisation (CGS), the initial lane alignment sequence (ILAS), and user data with frame/multiframe alignment character replacement. It also tracks SYNC~ re-synchronisation requests. It sits between the transport layer and the 8b/10b encoder and replaces the static link mux with a SYNC~-driven state machine.

Parameters:
F, 2, octets per frame (1..16)
K, 16, frames per multiframe (F*K must be 17..1024)
ILAS_MF, 4, number of ILAS multiframes (>=2)
SYNC_REQ_LEN, 5, consecutive low cycles of i_sync_n that constitute a resync request in DATA (>=1)

Ports:
clk  in  1  character clock
rst  in  1  synchronous reset, active-high
i_sync_n  in  1  SYNC~ from the receiver, already synchronous to clk; low = request CGS
i_data  in  8  user octet, HGFEDCBA
i_k  in  1  user octet is a control character
i_ilas_cfg  in  112  14 ILAS config octets; octet n = bits [8n+7:8n]
o_user_rdy  out  1  user octet is consumed this cycle (high only in DATA)
o_data  out  8  octet to the encoder
o_k  out  1  o_data is a control character
o_vld  out  1  o_data valid
o_state  out  2  0 CGS, 1 ILAS, 2 DATA
o_lmfc  out  1  one-cycle pulse on the first octet of each local multiframe

Behaviour:
- Reset (rst high at posedge): state = CGS; octet counter = 0; frame counter = 0; sync low counter = 0; o_data = 0; o_k = 0; o_vld = 0; o_state = 0; o_lmfc = 0.
- LMFC: the octet counter (0..F-1) and frame counter (0..K-1) run freely from reset in every state. A multiframe boundary occurs when both counters are 0. Local multiframe octet index m = frame*F + octet.
- Output timing: all outputs except o_user_rdy are registered and have 1-cycle latency from the counters and input sampling. o_lmfc is high in the cycle whose o_data is multiframe octet m = 0. o_vld is 1 in every cycle after reset.
- CGS: emit K28.5 (0xBC, k=1). Once i_sync_n has been sampled high, go to ILAS at the next multiframe boundary. The first ILAS octet is aligned to m = 0. If i_sync_n goes low before that boundary, the ILAS start is cancelled.
- ILAS: emit ILAS_MF multiframes.
  - m = 0: /R/ K28.0 (0x1C, k=1).
  - m = F*K-1: /A/ K28.3 (0x7C, k=1).
  - In multiframe index 1 only: m = 1 is /Q/ K28.4 (0x9C, k=1), and m = 2..15 are i_ilas_cfg octets 0..13 (k=0).
  - All other octets: data m[7:0] (k=0).
  - After the last /A/, go to DATA. The first DATA octet is at m = 0.
  - If i_sync_n is low at any cycle in ILAS, go to CGS on the next cycle.
- DATA:
  - o_user_rdy = 1. i_data and i_k are passed to the outputs with 1-cycle latency.
  - Character replacement: applies only on the last octet of a frame (octet = F-1), with i_k = 0, and only when the previous frame was also in DATA (never in the first frame after ILAS).
  - The comparison is against the stored original (unreplaced) last octet of the previous frame.
  - If that octet is also the multiframe end (m = F*K-1) and equal: replace with /A/ 0x7C, k=1.
  - Otherwise, if equal: replace with /F/ K28.7 (0xFC, k=1).
  - The stored previous octet updates on every frame end, with the original value.
  - Resync: a counter counts consecutive low samples of i_sync_n and clears when i_sync_n is high. When it reaches SYNC_REQ_LEN, go to CGS on the next cycle: the first K28.5 appears 1 cycle later on the outputs. Shorter low pulses are ignored.
- o_user_rdy = (state == DATA). It is combinational from the state register. The user must not assume acceptance while it is low.
- Reset mid-operation: this has priority over every transition and returns to CGS with the counters cleared.
- Simultaneous events: the resync/abort condition beats the ILAS completion and CGS→ILAS transitions in the same cycle.

Test Plan:
1. i_sync_n = 0 after reset for 100 cycles -> o_data = 0xBC, o_k = 1 every cycle from cycle 1; o_state = 0; o_lmfc pulses every 32 cycles (F = 2, K = 16).
2. i_sync_n rises at cycle 10 -> first /R/ 0x1C output coincides with the o_lmfc pulse at cycle 33.
   - 4×32 ILAS octets follow: /Q/ 0x9C at m = 1 of the 2nd multiframe, then the 14 cfg octets, and /A/ 0x7C ending each multiframe.
   - o_state = 2 follows immediately, with o_user_rdy high.
3. DATA, user octets 0x11,0x22 | 0x33,0x22 -> the 4th octet is output as 0xFC k=1.
   - With 0x22 repeated at m = 31 it is output as 0x7C k=1.
   - In the first frame after ILAS, an equal octet is not replaced.
4. DATA, i_sync_n low for 4 cycles then high -> stays in DATA. Low for 5 cycles -> 0xBC appears on the cycle after the 6th edge, o_state = 0.
5. i_sync_n low for 1 cycle during ILAS multiframe 2 -> CGS next cycle. A new ILAS starts at the next LMFC after i_sync_n returns high.
6. rst asserted for 1 cycle mid-DATA -> all outputs 0 the next cycle, then 0xBC. The LMFC restarts with o_lmfc at the 1st post-reset output octet.

Source files
------------

// File: rtl/tx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tx_link_ctrl
//
// Single-lane JESD204B transmit link controller. This block sits between the
// transport layer and the 8b/10b encoder. It produces the octet stream for the
// encoder:
//   - CGS : K28.5 comma characters while the receiver holds SYNC~ low.
//   - ILAS: ILAS_MF multiframes of the initial lane alignment sequence.
//           /R/ opens each multiframe and /A/ closes it. The second multiframe
//           carries /Q/ followed by the 14 link configuration octets.
//   - DATA: user octets. The last octet of a frame is replaced by an alignment
//           character (/F/ or /A/) when it repeats the previous frame's last
//           octet.
// A free-running local multiframe counter (LMFC) keeps all transitions aligned
// to multiframe boundaries. A sustained low on SYNC~ while in DATA returns the
// link to CGS.
//
// Parameters
//   F            octets per frame (1..16)
//   K            frames per multiframe (F*K in 17..1024)
//   ILAS_MF      number of ILAS multiframes (>= 2)
//   SYNC_REQ_LEN consecutive low SYNC~ samples that form a resync request
//
// Ports
//   clk         character clock
//   rst         synchronous reset, active high
//   i_sync_n    SYNC~ from the receiver (already in the clk domain), low = CGS
//   i_data      user octet (HGFEDCBA)
//   i_k         user octet is a control character
//   i_ilas_cfg  14 ILAS configuration octets, octet n = bits [8n+7:8n]
//   o_user_rdy  user octet consumed this cycle (combinational, DATA only)
//   o_data      octet to the 8b/10b encoder (registered)
//   o_k         o_data is a control character (registered)
//   o_vld       o_data valid (registered, high in every cycle after reset)
//   o_state     link state of the octet on o_data: 0 CGS, 1 ILAS, 2 DATA
//   o_lmfc      high with the first octet of every local multiframe
// -----------------------------------------------------------------------------
module tx_link_ctrl #(
    parameter int F            = 2,
    parameter int K            = 16,
    parameter int ILAS_MF      = 4,
    parameter int SYNC_REQ_LEN = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sync_n,
    input  logic [7:0]   i_data,
    input  logic         i_k,
    input  logic [111:0] i_ilas_cfg,
    output logic         o_user_rdy,
    output logic [7:0]   o_data,
    output logic         o_k,
    output logic         o_vld,
    output logic [1:0]   o_state,
    output logic         o_lmfc
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int MF_LEN = F * K;
    localparam int OW     = (F > 1) ? $clog2(F) : 1;
    localparam int FW     = (K > 1) ? $clog2(K) : 1;
    localparam int MW     = $clog2(MF_LEN);
    localparam int IW     = $clog2(ILAS_MF);
    localparam int SW     = $clog2(SYNC_REQ_LEN + 1);

    localparam logic [OW-1:0] OCT_LAST  = OW'(F - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(K - 1);
    localparam logic [MW-1:0] M_LAST    = MW'(MF_LEN - 1);
    localparam logic [MW-1:0] F_M       = MW'(F);
    localparam logic [IW-1:0] ILAS_LAST = IW'(ILAS_MF - 1);
    localparam logic [SW-1:0] SYNC_LIM  = SW'(SYNC_REQ_LEN);

    // Link states (values are also the o_state encoding)
    localparam logic [1:0] ST_CGS  = 2'd0;
    localparam logic [1:0] ST_ILAS = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Control characters
    localparam logic [7:0] K28_0 = 8'h1C;   // /R/ multiframe start (ILAS)
    localparam logic [7:0] K28_3 = 8'h7C;   // /A/ multiframe alignment
    localparam logic [7:0] K28_4 = 8'h9C;   // /Q/ config data follows
    localparam logic [7:0] K28_5 = 8'hBC;   // /K/ code group sync comma
    localparam logic [7:0] K28_7 = 8'hFC;   // /F/ frame alignment

    // ------------------------------------------------------------------
    // ILAS character at multiframe position m, returned as {k, octet}.
    // Positions other than the framing characters and the config block
    // carry the low byte of m as a ramp.
    // ------------------------------------------------------------------
    function automatic logic [8:0] ilas_char(
        input logic [MW-1:0] m,
        input logic          cfg_mf,
        input logic [111:0]  cfg
    );
        logic [8:0] r;
        logic [3:0] idx;
        r   = {1'b0, 8'(m)};
        idx = 4'(m - MW'(32'd2));
        if (m == {MW{1'b0}}) begin
            r = {1'b1, K28_0};
        end else if (m == M_LAST) begin
            r = {1'b1, K28_3};
        end else if (cfg_mf && (m == MW'(32'd1))) begin
            r = {1'b1, K28_4};
        end else if (cfg_mf && (m >= MW'(32'd2)) && (m <= MW'(32'd15))) begin
            r = {1'b0, cfg[{idx, 3'b000} +: 8]};
        end else begin
            r = {1'b0, 8'(m)};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic [OW-1:0] oct_r;
    logic [FW-1:0] frm_r;
    logic [MW-1:0] m_s;
    logic          frame_end_s;
    logic          mf_end_s;
    logic          mf_start_s;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [IW-1:0] ilas_mf_r;

    logic [SW-1:0] sync_cnt_r;
    logic [SW-1:0] sync_cnt_nxt_s;
    logic          sync_req_s;

    logic [7:0]    prev_last_r;
    logic          prev_vld_r;

    logic [7:0]    data_nxt_s;
    logic          k_nxt_s;

    // ------------------------------------------------------------------
    // LMFC position decode
    // ------------------------------------------------------------------

    // Multiframe position and boundary flags from the octet/frame counters
    always_comb begin
        m_s         = (MW'(frm_r) * F_M) + MW'(oct_r);
        frame_end_s = (oct_r == OCT_LAST);
        mf_end_s    = frame_end_s && (frm_r == FRM_LAST);
        mf_start_s  = (oct_r == {OW{1'b0}}) && (frm_r == {FW{1'b0}});
    end

    // Free-running octet/frame counters; they run in every link state
    always_ff @(posedge clk) begin
        if (rst) begin
            oct_r <= {OW{1'b0}};
            frm_r <= {FW{1'b0}};
        end else if (frame_end_s) begin
            oct_r <= {OW{1'b0}};
            if (frm_r == FRM_LAST) begin
                frm_r <= {FW{1'b0}};
            end else begin
                frm_r <= frm_r + FW'(1'b1);
            end
        end else begin
            oct_r <= oct_r + OW'(1'b1);
            frm_r <= frm_r;
        end
    end

    // ------------------------------------------------------------------
    // SYNC~ low-run detector
    // ------------------------------------------------------------------

    // Saturating count of consecutive low SYNC~ samples including this one
    always_comb begin
        if (i_sync_n) begin
            sync_cnt_nxt_s = {SW{1'b0}};
        end else if (sync_cnt_r == SYNC_LIM) begin
            sync_cnt_nxt_s = SYNC_LIM;
        end else begin
            sync_cnt_nxt_s = sync_cnt_r + SW'(1'b1);
        end
        sync_req_s = (sync_cnt_nxt_s == SYNC_LIM);
    end

    // Low-run counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt_r <= {SW{1'b0}};
        end else begin
            sync_cnt_r <= sync_cnt_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Link state machine
    // ------------------------------------------------------------------

    // Next state. State changes are taken on the last octet of a
    // multiframe so that the new state starts exactly at m = 0; SYNC~
    // aborts take priority over those boundary transitions.
    always_comb begin
        case (state_r)
            ST_CGS: begin
                if (i_sync_n && mf_end_s) begin
                    state_nxt_s = ST_ILAS;
                end else begin
                    state_nxt_s = ST_CGS;
                end
            end
            ST_ILAS: begin
                if (!i_sync_n) begin
                    state_nxt_s = ST_CGS;
                end else if (mf_end_s && (ilas_mf_r == ILAS_LAST)) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ILAS;
                end
            end
            ST_DATA: begin
                if (sync_req_s) begin
                    state_nxt_s = ST_CGS;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_CGS;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CGS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ILAS multiframe index; held at zero outside ILAS so each ILAS
    // attempt starts from its first multiframe
    always_ff @(posedge clk) begin
        if (rst) begin
            ilas_mf_r <= {IW{1'b0}};
        end else if (state_r != ST_ILAS) begin
            ilas_mf_r <= {IW{1'b0}};
        end else if (mf_end_s) begin
            ilas_mf_r <= ilas_mf_r + IW'(1'b1);
        end else begin
            ilas_mf_r <= ilas_mf_r;
        end
    end

    // ------------------------------------------------------------------
    // Alignment character replacement history
    // ------------------------------------------------------------------

    // Original last octet of the previous DATA frame. The valid flag is
    // dropped outside DATA so the first frame after ILAS is never replaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_last_r <= 8'h00;
            prev_vld_r  <= 1'b0;
        end else if ((state_r == ST_DATA) && frame_end_s) begin
            prev_last_r <= i_data;
            prev_vld_r  <= 1'b1;
        end else if (state_r != ST_DATA) begin
            prev_last_r <= prev_last_r;
            prev_vld_r  <= 1'b0;
        end else begin
            prev_last_r <= prev_last_r;
            prev_vld_r  <= prev_vld_r;
        end
    end

    // ------------------------------------------------------------------
    // Output octet selection
    // ------------------------------------------------------------------

    // Octet for the current state and multiframe position
    always_comb begin
        data_nxt_s = K28_5;
        k_nxt_s    = 1'b1;
        case (state_r)
            ST_CGS: begin
                data_nxt_s = K28_5;
                k_nxt_s    = 1'b1;
            end
            ST_ILAS: begin
                {k_nxt_s, data_nxt_s} = ilas_char(m_s, (ilas_mf_r == IW'(1'b1)), i_ilas_cfg);
            end
            ST_DATA: begin
                if (frame_end_s && !i_k && prev_vld_r && (i_data == prev_last_r)) begin
                    if (mf_end_s) begin
                        data_nxt_s = K28_3;
                    end else begin
                        data_nxt_s = K28_7;
                    end
                    k_nxt_s = 1'b1;
                end else begin
                    data_nxt_s = i_data;
                    k_nxt_s    = i_k;
                end
            end
            default: begin
                data_nxt_s = K28_5;
                k_nxt_s    = 1'b1;
            end
        endcase
    end

    // Registered encoder-side outputs; o_state reports the state that
    // produced the octet currently on o_data
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= 8'h00;
            o_k     <= 1'b0;
            o_vld   <= 1'b0;
            o_state <= ST_CGS;
            o_lmfc  <= 1'b0;
        end else begin
            o_data  <= data_nxt_s;
            o_k     <= k_nxt_s;
            o_vld   <= 1'b1;
            o_state <= state_r;
            o_lmfc  <= mf_start_s;
        end
    end

    // User octets are accepted only while the link is in DATA
    assign o_user_rdy = (state_r == ST_DATA);

endmodule
